mil_bc_sequencer: RTL and testbench
===================================

Name: mil_bc_sequencer

Overview:
- Bus-controller message sequencer for the MIL-STD-1553 link.
- Drives MIL_TXD with a command word (CW) and, for BC->RT transfers, a burst of data words (DW) from an internal 32x16 buffer.
- Then monitors MIL_RXD for the remote terminal's status word (SW) and, for RT->BC transfers, stores the returned data words into the same buffer.
- Sits between the host register interface and the MIL_TXD/MIL_RXD pair, and reports completion, the status word and error flags.

Parameters:
- RESP_TO, 1000: response/inter-word timeout in clk cycles (20 us at 50 MHz).
- TO_W, 11: timeout counter width; must satisfy 2^TO_W > RESP_TO.

Ports:
- clk  in  1  system clock, shared by MIL_TXD and MIL_RXD.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a message using cw_in.
- cw_in  in  16  command word: [15:11] RT address, [10] T/R (1 = RT->BC), [9:5] subaddress, [4:0] word count (0 means 32).
- wr_en  in  1  host buffer write strobe; ignored while busy=1.
- wr_addr  in  5  host buffer write address.
- wr_dat  in  16  host buffer write data.
- rd_addr  in  5  host buffer read address.
- rd_dat  out  16  buffer word at rd_addr, combinational read.
- tx_dat  out  16  word to MIL_TXD (dat).
- tx_en  out  1  MIL_TXD enable (txen). MIL_TXD sends CW sync on the first word of a burst and DW sync on the following words while tx_en stays high.
- tx_end  in  1  MIL_TXD T_end; one-cycle pulse at the end of each word.
- rx_ok  in  1  MIL_RXD ok_rx; one-cycle pulse when a word is received with valid parity.
- rx_sy_cw  in  1  MIL_RXD ok_SY_CW; qualifies rx_ok as a command/status-sync word.
- rx_dat  in  16  MIL_RXD data; valid when rx_ok=1.
- busy  out  1  message in progress.
- done  out  1  one-cycle completion pulse.
- sw  out  16  last received status word.
- rx_cnt  out  6  data words stored in the current RT->BC message.
- err_to  out  1  timeout error, valid from done until the next start.
- err_sync  out  1  wrong-sync word received.
- err_me  out  1  message-error bit (sw[10]) set in the received SW.

Behaviour:
- Reset values: all outputs 0; state IDLE. Buffer contents are not reset. Reset mid-message drops tx_en immediately.
- wc = cw_in[4:0], with 0 interpreted as 32; latched with cw_in on start.
- IDLE:
  - start=1 -> next cycle: busy=1, tx_dat=cw, tx_en=1; error flags, sw and rx_cnt clear; state TX_CW.
  - start while busy=1 is ignored.
- TX_CW, on tx_end:
  - T/R=0 -> tx_dat=buf[0], idx=1, state TX_DW.
  - T/R=1 -> tx_en=0, timer=0, state WAIT_SW.
- TX_DW, on tx_end:
  - idx==wc -> tx_en=0, timer=0, state WAIT_SW.
  - otherwise tx_dat=buf[idx], idx++.
  - tx_dat changes in the clock after tx_end; tx_en stays high for back-to-back words.
- WAIT_SW: timer increments each cycle.
  - rx_ok & rx_sy_cw -> sw=rx_dat, err_me=rx_dat[10].
    - T/R=1 -> idx=0, timer=0, state RX_DW.
    - T/R=0 -> state DONE.
  - rx_ok & !rx_sy_cw -> err_sync=1, state DONE.
  - timer==RESP_TO-1 -> err_to=1, state DONE.
- RX_DW: timer increments each cycle.
  - rx_ok & !rx_sy_cw -> buf[idx]=rx_dat, rx_cnt=idx+1, idx++, timer=0. When idx+1==wc -> state DONE.
  - rx_ok & rx_sy_cw -> err_sync=1, state DONE.
  - timeout -> err_to=1, state DONE; rx_cnt keeps the partial count.
- DONE: done=1 and busy=0 in the same cycle, then IDLE. A start may be accepted on the following cycle.
- rx_ok outside WAIT_SW/RX_DW (e.g. the receiver echoing our own transmission) is ignored.
- If rx_ok and timeout occur in the same cycle, rx_ok wins.
- Host read and internal write to the same address in the same cycle: rd_dat shows the old value.
- idx and rx_cnt are 6 bits wide so that a count of 32 is representable.

Test Plan:
- BC->RT: preload buf[0..2]=1111,2222,3333; start cw=16'h0823; after 4 tx_end pulses, rx_ok+rx_sy_cw with rx_dat=16'h0800 -> tx_dat sequence 0823,1111,2222,3333; tx_en continuous then 0; sw=0800; done pulse; no error flags.
- RT->BC: start cw=16'h0C22; after 1 tx_end: SW 16'h0800, then DWs 16'hABCD, 16'h6523 -> buf[0]=ABCD, buf[1]=6523; rx_cnt=2; done after the second DW.
- Timeout: start cw=16'h0821, no response after the 2nd tx_end -> done exactly RESP_TO cycles later with err_to=1, sw=0.
- Wrong sync: RT->BC wc=2; SW, then a word with rx_sy_cw=1 -> err_sync=1, rx_cnt=0, done. Separately, SW 16'h0C00 -> err_me=1.
- wc=0: cw=16'h0820 -> 33 words transmitted (CW + 32 DWs). Echo rx_ok during TX ignored; wr_en during busy leaves the buffer unchanged.
- rst_n low mid-TX_DW -> tx_en=0 and busy=0 immediately; a subsequent start runs a clean message.

Source files
------------

// File: rtl/mil_bc_sequencer.sv
// MIL-STD-1553 bus-controller message sequencer: sends CW (+DWs) on MIL_TXD, collects the SW
// (+DWs) from MIL_RXD into a shared 32x16 buffer and reports status/errors.
module mil_bc_sequencer #(
  parameter int unsigned RESP_TO = 1000,
  parameter int unsigned TO_W    = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] cw_in,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [15:0] wr_dat,
  input  logic [4:0]  rd_addr,
  output logic [15:0] rd_dat,
  output logic [15:0] tx_dat,
  output logic        tx_en,
  input  logic        tx_end,
  input  logic        rx_ok,
  input  logic        rx_sy_cw,
  input  logic [15:0] rx_dat,
  output logic        busy,
  output logic        done,
  output logic [15:0] sw,
  output logic [5:0]  rx_cnt,
  output logic        err_to,
  output logic        err_sync,
  output logic        err_me
);

  typedef enum logic [2:0] {StIdle, StTxCw, StTxDw, StWaitSw, StRxDw, StDone} state_e;

  localparam logic [TO_W-1:0] TimerLast = TO_W'(RESP_TO - 1);
  localparam logic [TO_W-1:0] TimerOne  = {{(TO_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             tr_q, tr_d;
  logic [5:0]       wc_q, wc_d;
  logic [5:0]       idx_q, idx_d;
  logic [TO_W-1:0]  timer_q, timer_d;
  logic [15:0]      tx_dat_q, tx_dat_d;
  logic [15:0]      sw_q, sw_d;
  logic [5:0]       rx_cnt_q, rx_cnt_d;
  logic             err_to_q, err_to_d;
  logic             err_sync_q, err_sync_d;
  logic             err_me_q, err_me_d;
  logic             timeout;

  logic [15:0]      mem [32];
  logic             mem_we;
  logic [4:0]       mem_waddr;
  logic [15:0]      mem_wdata;

  assign busy    = state_q inside {StTxCw, StTxDw, StWaitSw, StRxDw};
  assign tx_en   = state_q inside {StTxCw, StTxDw};
  assign done    = (state_q == StDone);
  assign timeout = (timer_q == TimerLast);

  always_comb begin
    state_d    = state_q;
    tr_d       = tr_q;
    wc_d       = wc_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    tx_dat_d   = tx_dat_q;
    sw_d       = sw_q;
    rx_cnt_d   = rx_cnt_q;
    err_to_d   = err_to_q;
    err_sync_d = err_sync_q;
    err_me_d   = err_me_q;
    mem_we     = wr_en && !busy;
    mem_waddr  = wr_addr;
    mem_wdata  = wr_dat;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StTxCw;
          tr_d       = cw_in[10];
          wc_d       = (cw_in[4:0] == 5'd0) ? 6'd32 : {1'b0, cw_in[4:0]};
          tx_dat_d   = cw_in;
          sw_d       = 16'h0000;
          rx_cnt_d   = 6'd0;
          err_to_d   = 1'b0;
          err_sync_d = 1'b0;
          err_me_d   = 1'b0;
        end
      end
      StTxCw: begin
        if (tx_end) begin
          if (!tr_q) begin
            tx_dat_d = mem[0];
            idx_d    = 6'd1;
            state_d  = StTxDw;
          end else begin
            timer_d = '0;
            state_d = StWaitSw;
          end
        end
      end
      StTxDw: begin
        if (tx_end) begin
          if (idx_q == wc_q) begin
            timer_d = '0;
            state_d = StWaitSw;
          end else begin
            tx_dat_d = mem[idx_q[4:0]];
            idx_d    = idx_q + 6'd1;
          end
        end
      end
      StWaitSw: begin
        timer_d = timer_q + TimerOne;
        // A received word takes priority over a coincident timeout.
        if (rx_ok) begin
          if (rx_sy_cw) begin
            sw_d     = rx_dat;
            err_me_d = rx_dat[10];
            if (tr_q) begin
              idx_d   = 6'd0;
              timer_d = '0;
              state_d = StRxDw;
            end else begin
              state_d = StDone;
            end
          end else begin
            err_sync_d = 1'b1;
            state_d    = StDone;
          end
        end else if (timeout) begin
          err_to_d = 1'b1;
          state_d  = StDone;
        end
      end
      StRxDw: begin
        timer_d = timer_q + TimerOne;
        if (rx_ok) begin
          if (!rx_sy_cw) begin
            mem_we    = 1'b1;
            mem_waddr = idx_q[4:0];
            mem_wdata = rx_dat;
            rx_cnt_d  = idx_q + 6'd1;
            idx_d     = idx_q + 6'd1;
            timer_d   = '0;
            if (idx_q + 6'd1 == wc_q) state_d = StDone;
          end else begin
            err_sync_d = 1'b1;
            state_d    = StDone;
          end
        end else if (timeout) begin
          err_to_d = 1'b1;
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      tr_q       <= 1'b0;
      wc_q       <= 6'd0;
      idx_q      <= 6'd0;
      timer_q    <= '0;
      tx_dat_q   <= 16'h0000;
      sw_q       <= 16'h0000;
      rx_cnt_q   <= 6'd0;
      err_to_q   <= 1'b0;
      err_sync_q <= 1'b0;
      err_me_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tr_q       <= tr_d;
      wc_q       <= wc_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      tx_dat_q   <= tx_dat_d;
      sw_q       <= sw_d;
      rx_cnt_q   <= rx_cnt_d;
      err_to_q   <= err_to_d;
      err_sync_q <= err_sync_d;
      err_me_q   <= err_me_d;
    end
  end

  // Buffer is deliberately not reset; reads are asynchronous so a same-cycle write shows old data.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign rd_dat   = mem[rd_addr];
  assign tx_dat   = tx_dat_q;
  assign sw       = sw_q;
  assign rx_cnt   = rx_cnt_q;
  assign err_to   = err_to_q;
  assign err_sync = err_sync_q;
  assign err_me   = err_me_q;

endmodule

// File: tb/tb_mil_bc_sequencer.sv
// Directed bench for mil_bc_sequencer: a table of whole messages plus hand-written
// sequences for mid-message start and reset.
module tb_mil_bc_sequencer;

  localparam int unsigned RESP_TO = 1000;
  localparam int unsigned TO_W    = 11;

  logic        clk, rst_n, start, wr_en, tx_end, rx_ok, rx_sy_cw;
  logic [15:0] cw_in, wr_dat, rd_dat, tx_dat, rx_dat, sw;
  logic [4:0]  wr_addr, rd_addr;
  logic        tx_en, busy, done, err_to, err_sync, err_me;
  logic [5:0]  rx_cnt;

  mil_bc_sequencer #(.RESP_TO(RESP_TO), .TO_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cw_in(cw_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_dat(wr_dat), .rd_addr(rd_addr), .rd_dat(rd_dat),
    .tx_dat(tx_dat), .tx_en(tx_en), .tx_end(tx_end),
    .rx_ok(rx_ok), .rx_sy_cw(rx_sy_cw), .rx_dat(rx_dat),
    .busy(busy), .done(done), .sw(sw), .rx_cnt(rx_cnt),
    .err_to(err_to), .err_sync(err_sync), .err_me(err_me)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cw;
    bit          has_sw;
    int          sw_delay;
    bit          sw_sync;
    logic [15:0] sw_word;
    int          n_dw;
    int          bad_idx;
    logic [15:0] dw0;
    logic [15:0] dw1;
    logic [15:0] exp_sw;
    bit          exp_to;
    bit          exp_sync;
    bit          exp_me;
    int          exp_cnt;
    int          exp_lat;
  } vec_t;

  vec_t        vecs[9];
  logic [15:0] model[32];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input int addr, input logic [15:0] dat);
    wr_en = 1'b1; wr_addr = 5'(addr); wr_dat = dat;
    tick();
    wr_en = 1'b0;
    model[addr] = dat;
  endtask

  task automatic pulse_rx(input bit sy, input logic [15:0] dat);
    rx_ok = 1'b1; rx_sy_cw = sy; rx_dat = dat;
    tick();
    rx_ok = 1'b0; rx_sy_cw = 1'b0;
  endtask

  function automatic logic [15:0] dw_of(input vec_t v, input int i);
    return (i == 0) ? v.dw0 : v.dw1;
  endfunction

  task automatic run_msg(input vec_t v);
    int nw, lat, wc;
    logic [15:0] exp_w;
    wc = (v.cw[4:0] == 5'd0) ? 32 : int'(v.cw[4:0]);
    nw = v.cw[10] ? 1 : wc + 1;
    cw_in = v.cw; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("flags_cleared", {err_to, err_sync, err_me}, 0);
    check("sw_cleared", sw, 0);
    check("rx_cnt_cleared", rx_cnt, 0);
    for (int w = 0; w < nw; w++) begin
      exp_w = (w == 0) ? v.cw : model[w-1];
      check("tx_dat_word", tx_dat, exp_w);
      check("tx_en_word", tx_en, 1);
      // Host write while busy and an echoed word must both be ignored.
      if (w == 0) begin
        wr_en = 1'b1; wr_addr = 5'd31; wr_dat = ~model[31];
      end
      rx_ok = 1'b1; rx_sy_cw = 1'b1; rx_dat = 16'hFFFF;
      tick();
      rx_ok = 1'b0; rx_sy_cw = 1'b0; wr_en = 1'b0;
      check("tx_en_hold", tx_en, 1);
      tx_end = 1'b1;
      tick();
      tx_end = 1'b0;
    end
    check("tx_en_off", tx_en, 0);
    check("busy_wait_sw", busy, 1);
    if (v.has_sw) begin
      repeat (v.sw_delay) tick();
      pulse_rx(v.sw_sync, v.sw_word);
    end
    for (int i = 0; i < v.n_dw; i++) begin
      repeat (2) tick();
      rd_addr = 5'(i);
      rx_ok = 1'b1; rx_sy_cw = (i == v.bad_idx); rx_dat = dw_of(v, i);
      #1;
      check("rd_old_same_cycle", rd_dat, model[i]);
      tick();
      rx_ok = 1'b0; rx_sy_cw = 1'b0;
      if (i != v.bad_idx) model[i] = dw_of(v, i);
      check("rd_after_rx", rd_dat, model[i]);
    end
    lat = 0;
    while (!done && lat < int'(RESP_TO) + 20) begin
      tick();
      lat++;
    end
    check("done_latency", lat, v.exp_lat);
    check("done_pulse", done, 1);
    check("busy_at_done", busy, 0);
    check("sw", sw, v.exp_sw);
    check("err_to", err_to, v.exp_to);
    check("err_sync", err_sync, v.exp_sync);
    check("err_me", err_me, v.exp_me);
    check("rx_cnt", rx_cnt, v.exp_cnt);
    tick();
    check("done_one_cycle", done, 0);
    check("flags_held", {err_to, err_sync, err_me}, {v.exp_to, v.exp_sync, v.exp_me});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        cw    sw dly sy sw_word n  bad dw0      dw1      exp_sw to sy me cnt lat
    vecs[0] = '{16'h0823, 1, 2, 1, 16'h0800, 0, -1, 16'h0, 16'h0, 16'h0800, 0, 0, 0, 0, 0};
    vecs[1] = '{16'h0C22, 1, 2, 1, 16'h0800, 2, -1, 16'hABCD, 16'h6523, 16'h0800, 0, 0, 0, 2, 0};
    vecs[2] = '{16'h0C22, 1, 2, 1, 16'h0800, 1, 0, 16'h1234, 16'h0, 16'h0800, 0, 1, 0, 0, 0};
    vecs[3] = '{16'h0821, 1, 3, 1, 16'h0C00, 0, -1, 16'h0, 16'h0, 16'h0C00, 0, 0, 1, 0, 0};
    vecs[4] = '{16'h0821, 1, 1, 0, 16'h0800, 0, -1, 16'h0, 16'h0, 16'h0000, 0, 1, 0, 0, 0};
    vecs[5] = '{16'h0821, 0, 0, 0, 16'h0, 0, -1, 16'h0, 16'h0, 16'h0000, 1, 0, 0, 0, RESP_TO};
    vecs[6] = '{16'h0C22, 1, 2, 1, 16'h0800, 1, -1, 16'h7777, 16'h0, 16'h0800, 1, 0, 0, 1,
                RESP_TO};
    vecs[7] = '{16'h0C41, 1, RESP_TO - 1, 1, 16'h0800, 1, -1, 16'h5A5A, 16'h0, 16'h0800,
                0, 0, 0, 1, 0};
    vecs[8] = '{16'h0820, 1, 2, 1, 16'h0800, 0, -1, 16'h0, 16'h0, 16'h0800, 0, 0, 0, 0, 0};

    rst_n = 1'b0; start = 1'b0; cw_in = '0; wr_en = 1'b0; wr_addr = '0; wr_dat = '0;
    rd_addr = '0; tx_end = 1'b0; rx_ok = 1'b0; rx_sy_cw = 1'b0; rx_dat = '0;
    #12;
    check("rst_outputs", {tx_dat, tx_en, busy, done, sw, rx_cnt, err_to, err_sync, err_me}, 0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);
    check("idle_tx_en", tx_en, 0);

    for (int i = 0; i < 32; i++) host_wr(i, 16'h4000 + 16'(i * 16'h0101));
    host_wr(0, 16'h1111);
    host_wr(1, 16'h2222);
    host_wr(2, 16'h3333);
    rd_addr = 5'd2;
    #1;
    check("host_rd", rd_dat, 16'h3333);

    for (int i = 0; i < 9; i++) run_msg(vecs[i]);

    // Start during a message is ignored; reset mid-TX_DW drops tx_en/busy at once.
    cw_in = 16'h0823; start = 1'b1;
    tick();
    start = 1'b0;
    tx_end = 1'b1;
    tick();
    tx_end = 1'b0;
    check("txdw_first", tx_dat, model[0]);
    cw_in = 16'h0C01; start = 1'b1;
    tick();
    start = 1'b0;
    check("start_ignored_dat", tx_dat, model[0]);
    check("start_ignored_en", tx_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_tx_en", tx_en, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_dat", tx_dat, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", busy, 0);
    run_msg(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
